// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU type definitions.
//   t_alu_op : ALU operation code carried from decode to the ALU.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } t_alu_op;

endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: bundle of the decode-side offer, the MEM/WB forwarding
// taps and the EX/ALU-side entry of the ID->EX operand stage.
//   master modport : environment view (drives offers, forwarding, out_ready, flush)
//   slave  modport : stage view (drives in_ready, out_valid and the held entry)
interface alu_operand_stage_if #(
    parameter int XLEN     = 32,
    parameter int REG_IDXW = 5
);
    import cpu_pkg::*;

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    t_alu_op             in_alu_op;
    logic [REG_IDXW-1:0] in_rs1_idx;
    logic [REG_IDXW-1:0] in_rs2_idx;
    logic [XLEN-1:0]     in_rs1_data;
    logic [XLEN-1:0]     in_rs2_data;
    logic [XLEN-1:0]     in_imm;
    logic [XLEN-1:0]     in_pc;
    logic                in_sel_pc;
    logic                in_sel_imm;
    logic [REG_IDXW-1:0] in_rd_idx;
    logic                in_rd_we;
    logic                fwd_mem_we;
    logic [REG_IDXW-1:0] fwd_mem_rd;
    logic [XLEN-1:0]     fwd_mem_data;
    logic                fwd_wb_we;
    logic [REG_IDXW-1:0] fwd_wb_rd;
    logic [XLEN-1:0]     fwd_wb_data;
    logic                out_valid;
    logic                out_ready;
    t_alu_op             alu_op;
    logic [XLEN-1:0]     alu_in1;
    logic [XLEN-1:0]     alu_in2;
    logic [REG_IDXW-1:0] out_rd_idx;
    logic                out_rd_we;
    logic [XLEN-1:0]     out_pc;

    modport master (
        output flush, in_valid, in_alu_op, in_rs1_idx, in_rs2_idx, in_rs1_data,
               in_rs2_data, in_imm, in_pc, in_sel_pc, in_sel_imm, in_rd_idx,
               in_rd_we, fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we,
               fwd_wb_rd, fwd_wb_data, out_ready,
        input  in_ready, out_valid, alu_op, alu_in1, alu_in2, out_rd_idx,
               out_rd_we, out_pc
    );

    modport slave (
        input  flush, in_valid, in_alu_op, in_rs1_idx, in_rs2_idx, in_rs1_data,
               in_rs2_data, in_imm, in_pc, in_sel_pc, in_sel_imm, in_rd_idx,
               in_rd_we, fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we,
               fwd_wb_rd, fwd_wb_data, out_ready,
        output in_ready, out_valid, alu_op, alu_in1, alu_in2, out_rd_idx,
               out_rd_we, out_pc
    );

endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: single-entry ID->EX register feeding the ALU.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : slave view of alu_operand_stage_if
//           in_*      decoded instruction offer (valid/ready)
//           fwd_mem_* / fwd_wb_* : MEM and WB result taps for RAW hazards
//           out_valid/out_ready, alu_op, alu_in1/2, out_rd_*, out_pc toward EX
// Register operands are forwarded when captured, refreshed from the forwarding
// taps every cycle while stalled, and overridden combinationally on the way out,
// so a producer that retires during a stall is never missed.
module alu_operand_stage #(
    parameter int XLEN     = 32,
    parameter int REG_IDXW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave bus
);
    import cpu_pkg::*;

    // MEM has priority over WB; x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_value(
        input logic [REG_IDXW-1:0] idx,
        input logic [XLEN-1:0]     d,
        input logic                mem_we,
        input logic [REG_IDXW-1:0] mem_rd,
        input logic [XLEN-1:0]     mem_data,
        input logic                wb_we,
        input logic [REG_IDXW-1:0] wb_rd,
        input logic [XLEN-1:0]     wb_data
    );
        logic [XLEN-1:0] r;
        if (idx == {REG_IDXW{1'b0}}) begin
            r = d;
        end else if (mem_we && (mem_rd == idx)) begin
            r = mem_data;
        end else if (wb_we && (wb_rd == idx)) begin
            r = wb_data;
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic                valid_r,    valid_s;
    t_alu_op             op_r,       op_s;
    logic [XLEN-1:0]     op1_r,      op1_s;
    logic [XLEN-1:0]     op2_r,      op2_s;
    logic [REG_IDXW-1:0] idx1_r,     idx1_s;
    logic [REG_IDXW-1:0] idx2_r,     idx2_s;
    logic                src1_reg_r, src1_reg_s;
    logic                src2_reg_r, src2_reg_s;
    logic [REG_IDXW-1:0] rd_idx_r,   rd_idx_s;
    logic                rd_we_r,    rd_we_s;
    logic [XLEN-1:0]     pc_r,       pc_s;

    logic                in_ready_s;
    logic                accept_s;
    logic [XLEN-1:0]     cap_rs1_s;
    logic [XLEN-1:0]     cap_rs2_s;
    logic [XLEN-1:0]     held_fwd1_s;
    logic [XLEN-1:0]     held_fwd2_s;

    // Handshake and forwarding views of both the offered and the held operands.
    always_comb begin
        in_ready_s  = (!valid_r) || bus.out_ready;
        accept_s    = bus.in_valid && in_ready_s;
        cap_rs1_s   = fwd_value(bus.in_rs1_idx, bus.in_rs1_data,
                                bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                                bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data);
        cap_rs2_s   = fwd_value(bus.in_rs2_idx, bus.in_rs2_data,
                                bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                                bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data);
        held_fwd1_s = fwd_value(idx1_r, op1_r,
                                bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                                bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data);
        held_fwd2_s = fwd_value(idx2_r, op2_r,
                                bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                                bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data);
    end

    // Next-state selection: flush, then accept, then consume, then hold/snoop.
    always_comb begin
        valid_s    = valid_r;
        op_s       = op_r;
        op1_s      = op1_r;
        op2_s      = op2_r;
        idx1_s     = idx1_r;
        idx2_s     = idx2_r;
        src1_reg_s = src1_reg_r;
        src2_reg_s = src2_reg_r;
        rd_idx_s   = rd_idx_r;
        rd_we_s    = rd_we_r;
        pc_s       = pc_r;
        if (bus.flush) begin
            valid_s = 1'b0;
        end else if (accept_s) begin
            valid_s    = 1'b1;
            op_s       = bus.in_alu_op;
            op1_s      = bus.in_sel_pc  ? bus.in_pc  : cap_rs1_s;
            op2_s      = bus.in_sel_imm ? bus.in_imm : cap_rs2_s;
            idx1_s     = bus.in_rs1_idx;
            idx2_s     = bus.in_rs2_idx;
            src1_reg_s = !bus.in_sel_pc;
            src2_reg_s = !bus.in_sel_imm;
            rd_idx_s   = bus.in_rd_idx;
            rd_we_s    = bus.in_rd_we;
            pc_s       = bus.in_pc;
        end else if (valid_r && bus.out_ready) begin
            valid_s = 1'b0;
        end else if (valid_r) begin
            // Stalled: absorb any producer retiring this cycle.
            op1_s = src1_reg_r ? held_fwd1_s : op1_r;
            op2_s = src2_reg_r ? held_fwd2_s : op2_r;
        end else begin
            valid_s = 1'b0;
        end
    end

    // Entry register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            op_r       <= ALU_ADD;
            op1_r      <= {XLEN{1'b0}};
            op2_r      <= {XLEN{1'b0}};
            idx1_r     <= {REG_IDXW{1'b0}};
            idx2_r     <= {REG_IDXW{1'b0}};
            src1_reg_r <= 1'b0;
            src2_reg_r <= 1'b0;
            rd_idx_r   <= {REG_IDXW{1'b0}};
            rd_we_r    <= 1'b0;
            pc_r       <= {XLEN{1'b0}};
        end else begin
            valid_r    <= valid_s;
            op_r       <= op_s;
            op1_r      <= op1_s;
            op2_r      <= op2_s;
            idx1_r     <= idx1_s;
            idx2_r     <= idx2_s;
            src1_reg_r <= src1_reg_s;
            src2_reg_r <= src2_reg_s;
            rd_idx_r   <= rd_idx_s;
            rd_we_r    <= rd_we_s;
            pc_r       <= pc_s;
        end
    end

    // Operands get a last-moment forwarding override so EX sees same-cycle results.
    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = valid_r;
    assign bus.alu_op     = op_r;
    assign bus.alu_in1    = src1_reg_r ? held_fwd1_s : op1_r;
    assign bus.alu_in2    = src2_reg_r ? held_fwd2_s : op2_r;
    assign bus.out_rd_idx = rd_idx_r;
    assign bus.out_rd_we  = rd_we_r;
    assign bus.out_pc     = pc_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the operand stage.
module tb_alu_operand_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_operand_stage_if #(.XLEN(32), .REG_IDXW(5)) bif ();

    alu_operand_stage #(.XLEN(32), .REG_IDXW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: one slot holding the instruction as the ALU should see it.
    logic        m_valid;
    t_alu_op     m_op;
    logic [31:0] m_v1, m_v2, m_pc;
    logic [4:0]  m_i1, m_i2, m_rd;
    logic        m_r1, m_r2, m_we;

    function automatic logic [31:0] mfwd(input logic [4:0] idx, input logic [31:0] d);
        if (idx != 5'd0 && bif.fwd_mem_we && bif.fwd_mem_rd == idx) return bif.fwd_mem_data;
        if (idx != 5'd0 && bif.fwd_wb_we && bif.fwd_wb_rd == idx) return bif.fwd_wb_data;
        return d;
    endfunction

    function automatic logic [31:0] exp_in1();
        return m_r1 ? mfwd(m_i1, m_v1) : m_v1;
    endfunction

    function automatic logic [31:0] exp_in2();
        return m_r2 ? mfwd(m_i2, m_v2) : m_v2;
    endfunction

    // Advance one clock and update the model from the inputs present at the edge.
    task automatic tick();
        logic acc;
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_op = ALU_ADD; m_v1 = 32'd0; m_v2 = 32'd0; m_pc = 32'd0;
            m_i1 = 5'd0; m_i2 = 5'd0; m_rd = 5'd0; m_r1 = 1'b0; m_r2 = 1'b0; m_we = 1'b0;
        end else begin
            acc = bif.in_valid && (!m_valid || bif.out_ready);
            if (bif.flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_op = bif.in_alu_op;
                m_r1 = !bif.in_sel_pc;
                m_r2 = !bif.in_sel_imm;
                m_i1 = bif.in_rs1_idx;
                m_i2 = bif.in_rs2_idx;
                m_v1 = bif.in_sel_pc  ? bif.in_pc  : mfwd(bif.in_rs1_idx, bif.in_rs1_data);
                m_v2 = bif.in_sel_imm ? bif.in_imm : mfwd(bif.in_rs2_idx, bif.in_rs2_data);
                m_rd = bif.in_rd_idx;
                m_we = bif.in_rd_we;
                m_pc = bif.in_pc;
            end else if (m_valid && bif.out_ready) begin
                m_valid = 1'b0;
            end else if (m_valid) begin
                if (m_r1) m_v1 = mfwd(m_i1, m_v1);
                if (m_r2) m_v2 = mfwd(m_i2, m_v2);
            end
        end
        #1;
    endtask

    task automatic drive_idle();
        bif.flush = 1'b0;        bif.in_valid = 1'b0;     bif.in_alu_op = ALU_ADD;
        bif.in_rs1_idx = 5'd0;   bif.in_rs2_idx = 5'd0;   bif.in_rs1_data = 32'd0;
        bif.in_rs2_data = 32'd0; bif.in_imm = 32'd0;      bif.in_pc = 32'd0;
        bif.in_sel_pc = 1'b0;    bif.in_sel_imm = 1'b0;   bif.in_rd_idx = 5'd0;
        bif.in_rd_we = 1'b0;     bif.fwd_mem_we = 1'b0;   bif.fwd_mem_rd = 5'd0;
        bif.fwd_mem_data = 32'd0; bif.fwd_wb_we = 1'b0;   bif.fwd_wb_rd = 5'd0;
        bif.fwd_wb_data = 32'd0; bif.out_ready = 1'b0;
    endtask

    task automatic offer(input t_alu_op op, input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2);
        bif.in_valid = 1'b1; bif.in_alu_op = op;
        bif.in_rs1_idx = r1; bif.in_rs1_data = d1;
        bif.in_rs2_idx = r2; bif.in_rs2_data = d2;
        bif.in_rd_idx = 5'd10; bif.in_rd_we = 1'b1; bif.in_pc = 32'h40;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        n_vec++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bif.out_valid); end
        n_vec++; if (bif.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", bif.in_ready); end
        n_vec++; if (bif.alu_op !== ALU_ADD) begin n_err++; $display("FAIL reset_op got %0d want %0d", bif.alu_op, ALU_ADD); end
        n_vec++; if (bif.alu_in1 !== 32'd0 || bif.alu_in2 !== 32'd0) begin n_err++; $display("FAIL reset_ops got %h/%h want 0/0", bif.alu_in1, bif.alu_in2); end
        n_vec++; if (bif.out_pc !== 32'd0 || bif.out_rd_idx !== 5'd0 || bif.out_rd_we !== 1'b0) begin n_err++; $display("FAIL reset_meta got pc=%h rd=%0d we=%0b want 0", bif.out_pc, bif.out_rd_idx, bif.out_rd_we); end
    endtask

    task automatic test_basic_add();
        drive_idle();
        offer(ALU_ADD, 5'd5, 32'd7, 5'd6, 32'd9);
        tick();
        drive_idle();
        #1;
        n_vec++; if (bif.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %0b want 1", bif.out_valid); end
        n_vec++; if (bif.alu_in1 !== 32'd7) begin n_err++; $display("FAIL add_in1 got %h want 7", bif.alu_in1); end
        n_vec++; if (bif.alu_in2 !== 32'd9) begin n_err++; $display("FAIL add_in2 got %h want 9", bif.alu_in2); end
        n_vec++; if (bif.alu_op !== ALU_ADD) begin n_err++; $display("FAIL add_op got %0d want %0d", bif.alu_op, ALU_ADD); end
        n_vec++; if (bif.in_ready !== 1'b0) begin n_err++; $display("FAIL add_stall_ready got %0b want 0", bif.in_ready); end
        // Stall 3 cycles; WB writes x6 only in the second cycle.
        bif.fwd_wb_we = 1'b1; bif.fwd_wb_rd = 5'd6; bif.fwd_wb_data = 32'hABCD;
        #1;
        n_vec++; if (bif.alu_in2 !== 32'hABCD) begin n_err++; $display("FAIL snoop_c2 got %h want 0000abcd", bif.alu_in2); end
        tick();
        bif.fwd_wb_we = 1'b0; bif.fwd_wb_data = 32'h0;
        #1;
        n_vec++; if (bif.alu_in2 !== 32'hABCD) begin n_err++; $display("FAIL snoop_c3 got %h want 0000abcd", bif.alu_in2); end
        tick();
        n_vec++; if (bif.alu_in2 !== 32'hABCD || bif.out_valid !== 1'b1) begin n_err++; $display("FAIL snoop_c4 got %h v=%0b want 0000abcd v=1", bif.alu_in2, bif.out_valid); end
        bif.out_ready = 1'b1;
        tick();
        drive_idle();
        #1;
        n_vec++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL consume_valid got %0b want 0", bif.out_valid); end
    endtask

    task automatic test_fwd_priority();
        drive_idle();
        offer(ALU_SUB, 5'd3, 32'h11, 5'd4, 32'h22);
        bif.fwd_mem_we = 1'b1; bif.fwd_mem_rd = 5'd3; bif.fwd_mem_data = 32'h55;
        bif.fwd_wb_we  = 1'b1; bif.fwd_wb_rd  = 5'd3; bif.fwd_wb_data  = 32'h66;
        tick();
        drive_idle(); bif.out_ready = 1'b1;
        #1;
        n_vec++; if (bif.alu_in1 !== 32'h55) begin n_err++; $display("FAIL mem_over_wb got %h want 00000055", bif.alu_in1); end
        n_vec++; if (bif.alu_in2 !== 32'h22) begin n_err++; $display("FAIL unfwd_in2 got %h want 00000022", bif.alu_in2); end
        tick();
    endtask

    task automatic test_pc_imm();
        drive_idle();
        offer(ALU_OR, 5'd1, 32'h1, 5'd2, 32'h2);
        bif.in_sel_pc = 1'b1; bif.in_sel_imm = 1'b1;
        bif.in_pc = 32'h100; bif.in_imm = 32'hFFFF_FFFC;
        bif.fwd_mem_we = 1'b1; bif.fwd_mem_rd = 5'd1; bif.fwd_mem_data = 32'hDEAD;
        tick();
        bif.in_valid = 1'b0; bif.out_ready = 1'b0; bif.fwd_mem_rd = 5'd2;
        #1;
        n_vec++; if (bif.alu_in1 !== 32'h100) begin n_err++; $display("FAIL pc_operand got %h want 00000100", bif.alu_in1); end
        n_vec++; if (bif.alu_in2 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL imm_operand got %h want fffffffc", bif.alu_in2); end
        n_vec++; if (bif.out_pc !== 32'h100) begin n_err++; $display("FAIL out_pc got %h want 00000100", bif.out_pc); end
        bif.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_x0();
        drive_idle();
        offer(ALU_AND, 5'd0, 32'd0, 5'd0, 32'd0);
        bif.fwd_mem_we = 1'b1; bif.fwd_mem_rd = 5'd0; bif.fwd_mem_data = 32'h1234;
        tick();
        bif.in_valid = 1'b0;
        #1;
        n_vec++; if (bif.alu_in1 !== 32'd0) begin n_err++; $display("FAIL x0_in1 got %h want 0", bif.alu_in1); end
        n_vec++; if (bif.alu_in2 !== 32'd0) begin n_err++; $display("FAIL x0_in2 got %h want 0", bif.alu_in2); end
        bif.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        drive_idle();
        offer(ALU_XOR, 5'd7, 32'h7, 5'd8, 32'h8);
        tick();
        offer(ALU_SLT, 5'd9, 32'h9, 5'd1, 32'h1);
        bif.flush = 1'b1; bif.out_ready = 1'b1;
        #1;
        n_vec++; if (bif.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0b want 1", bif.in_ready); end
        tick();
        drive_idle(); bif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid cyc %0d got %0b want 0", i, bif.out_valid); end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        drive_idle();
        offer(ALU_SRA, 5'd2, 32'h2, 5'd3, 32'h3);
        tick();
        drive_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++; if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin n_err++; $display("FAIL midreset got v=%0b r=%0b want v=0 r=1", bif.out_valid, bif.in_ready); end
    endtask

    task automatic test_back_to_back();
        drive_idle();
        bif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(ALU_ADD, 5'd11, 32'h100 + i, 5'd12, 32'h200 + i);
            tick();
            #1;
            n_vec++; if (bif.out_valid !== 1'b1 || bif.alu_in1 !== (32'h100 + i)) begin n_err++; $display("FAIL b2b %0d got v=%0b in1=%h want v=1 in1=%h", i, bif.out_valid, bif.alu_in1, 32'h100 + i); end
        end
        drive_idle();
        bif.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bif.in_valid     = ($urandom_range(0, 3) != 0);
            bif.in_alu_op    = t_alu_op'($urandom_range(0, 9));
            bif.in_rs1_idx   = 5'($urandom_range(0, 3));
            bif.in_rs2_idx   = 5'($urandom_range(0, 3));
            bif.in_rs1_data  = $urandom;
            bif.in_rs2_data  = $urandom;
            bif.in_imm       = $urandom;
            bif.in_pc        = $urandom;
            bif.in_sel_pc    = ($urandom_range(0, 3) == 0);
            bif.in_sel_imm   = ($urandom_range(0, 3) == 0);
            bif.in_rd_idx    = 5'($urandom_range(0, 31));
            bif.in_rd_we     = 1'($urandom_range(0, 1));
            bif.fwd_mem_we   = 1'($urandom_range(0, 1));
            bif.fwd_mem_rd   = 5'($urandom_range(0, 3));
            bif.fwd_mem_data = $urandom;
            bif.fwd_wb_we    = 1'($urandom_range(0, 1));
            bif.fwd_wb_rd    = 5'($urandom_range(0, 3));
            bif.fwd_wb_data  = $urandom;
            bif.out_ready    = ($urandom_range(0, 2) != 0);
            bif.flush        = ($urandom_range(0, 15) == 0);
            #1;
            n_vec++; if (bif.out_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid c%0d got %0b want %0b", c, bif.out_valid, m_valid); end
            n_vec++; if (bif.in_ready !== (!m_valid || bif.out_ready)) begin n_err++; $display("FAIL rnd_ready c%0d got %0b want %0b", c, bif.in_ready, !m_valid || bif.out_ready); end
            if (m_valid) begin
                n_vec++; if (bif.alu_in1 !== exp_in1()) begin n_err++; $display("FAIL rnd_in1 c%0d got %h want %h", c, bif.alu_in1, exp_in1()); end
                n_vec++; if (bif.alu_in2 !== exp_in2()) begin n_err++; $display("FAIL rnd_in2 c%0d got %h want %h", c, bif.alu_in2, exp_in2()); end
                n_vec++; if (bif.alu_op !== m_op || bif.out_pc !== m_pc || bif.out_rd_idx !== m_rd || bif.out_rd_we !== m_we) begin
                    n_err++; $display("FAIL rnd_meta c%0d got op=%0d pc=%h rd=%0d we=%0b want op=%0d pc=%h rd=%0d we=%0b",
                                      c, bif.alu_op, bif.out_pc, bif.out_rd_idx, bif.out_rd_we, m_op, m_pc, m_rd, m_we);
                end
            end
            tick();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive_idle();
        #2;
        test_reset();
        test_basic_add();
        test_fwd_priority();
        test_pc_imm();
        test_x0();
        test_flush();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
